// File: rtl/info_frame_builder_pkg.sv
// rtl/info_frame_builder_pkg.sv - shared types and packing helper for the InfoFrame builder
// Purpose: FSM state enum, InfoFrame payload limit, PB array/subpacket types,
//          and the function that packs PB0..PB27 into the four subpackets.
// Ports:   none (package)
package info_frame_builder_pkg;

  localparam int INFO_FRAME_MAX_PB = 27;

  typedef enum logic [1:0] {IDLE, SUM, SWAP} info_frame_state_t;

  // PB0 (checksum) lives in element 0
  typedef logic [INFO_FRAME_MAX_PB:0][7:0] pb_array_t;
  typedef logic [3:0][55:0] sub_t;

  // sub[i] = {PB[7i+6], ..., PB[7i]}
  function automatic sub_t pack_pb(input pb_array_t pb);
    sub_t s;
    for (int i = 0; i < 4; i++) begin
      s[i] = pb[7*i +: 7];
    end
    return s;
  endfunction

endpackage

// File: rtl/info_frame_builder_if.sv
// rtl/info_frame_builder_if.sv - control/config and packet output bundle of the InfoFrame builder
// Purpose: groups shadow-write, header, commit/hold inputs and the packet outputs.
// Ports:   master drives wr_*/hdr_*/commit/hold and reads status/packet;
//          slave (the builder) is the reverse.
interface info_frame_builder_if;
  import info_frame_builder_pkg::*;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  hdr_type;
  logic [7:0]  hdr_version;
  logic [4:0]  hdr_length;
  logic        commit;
  logic        hold;
  logic        busy;
  logic        valid;
  logic        updated;
  logic        length_error;
  logic [23:0] header;
  sub_t        sub;

  modport master (
    output wr_en, wr_addr, wr_data, hdr_type, hdr_version, hdr_length, commit, hold,
    input  busy, valid, updated, length_error, header, sub
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, hdr_type, hdr_version, hdr_length, commit, hold,
    output busy, valid, updated, length_error, header, sub
  );

endinterface

// File: rtl/info_frame_builder_checksum_acc.sv
// rtl/info_frame_builder_checksum_acc.sv - sequential InfoFrame checksum accumulator
// Purpose: holds the running mod-256 sum and the payload index; one byte per run cycle.
// Ports:   clk, reset; start/init load the header sum and clear idx; run adds
//          data (masked by idx < len) and advances idx; acc, idx, done out.
module info_frame_builder_checksum_acc #(
  parameter int MAX_PAYLOAD = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] init,
  input  logic       run,
  input  logic [4:0] len,
  input  logic [7:0] data,
  output logic [7:0] acc,
  output logic [4:0] idx,
  output logic       done
);

  // done marks the cycle whose add is the last payload byte
  assign done = (idx == 5'(MAX_PAYLOAD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      idx <= '0;
    end else if (start) begin
      acc <= init;
      idx <= '0;
    end else if (run) begin
      if (idx < len) begin
        acc <= acc + data;
      end
      idx <= idx + 5'd1;
    end
  end

endmodule

// File: rtl/info_frame_builder.sv
// rtl/info_frame_builder.sv - runtime-programmable HDMI InfoFrame source with shadow payload
// Purpose: byte-writable shadow payload; commit latches the header, sums the
//          checksum sequentially, then swaps into the active packet when hold is low.
// Ports:   clk_pixel, reset (sync, active high); bus (slave modport): shadow
//          writes, header fields, commit/hold in; busy/valid/updated/length_error,
//          header[23:0], sub[3:0][55:0] out.
module info_frame_builder
  import info_frame_builder_pkg::*;
#(
  parameter int MAX_PAYLOAD   = 27,
  parameter int CLEAR_ON_SWAP = 0
) (
  input logic                 clk_pixel,
  input logic                 reset,
  info_frame_builder_if.slave bus
);

  info_frame_state_t state_q, state_d;

  logic [7:0]  shadow [MAX_PAYLOAD];
  logic [23:0] hdr_q;
  logic [23:0] header_q;
  sub_t        sub_q;
  logic        valid_q, updated_q, lerr_q;

  logic        busy, start, swap, reject, wr_ok, done;
  logic [7:0]  acc, hdr_sum;
  logic [4:0]  idx;
  pb_array_t   pb_next;

  assign busy    = (state_q != IDLE);
  assign wr_ok   = bus.wr_en && !busy && (32'(bus.wr_addr) < MAX_PAYLOAD);
  assign hdr_sum = {1'b1, bus.hdr_type} + bus.hdr_version + {3'b000, bus.hdr_length};

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    swap    = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.commit) begin
          if (32'(bus.hdr_length) > MAX_PAYLOAD) begin
            reject = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = SUM;
          end
        end
      end
      SUM: begin
        if (done) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        if (!bus.hold) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  info_frame_builder_checksum_acc #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_acc (
    .clk   (clk_pixel),
    .reset (reset),
    .start (start),
    .init  (hdr_sum),
    .run   (state_q == SUM),
    .len   (hdr_q[20:16]),
    .data  (shadow[idx]),
    .acc   (acc),
    .idx   (idx),
    .done  (done)
  );

  // Writes are blocked while busy, so a clear on swap never races a write
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      for (int k = 0; k < MAX_PAYLOAD; k++) shadow[k] <= '0;
    end else if (swap && (CLEAR_ON_SWAP != 0)) begin
      for (int k = 0; k < MAX_PAYLOAD; k++) shadow[k] <= '0;
    end else if (wr_ok) begin
      shadow[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Bytes at or beyond the latched length are sent as zero
  always_comb begin
    pb_next    = '0;
    pb_next[0] = (~acc) + 8'd1;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (k < 32'(hdr_q[20:16])) begin
        pb_next[k+1] = shadow[k];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hdr_q     <= '0;
      header_q  <= '0;
      sub_q     <= '0;
      valid_q   <= 1'b0;
      updated_q <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      updated_q <= swap;
      lerr_q    <= reject;
      if (start) begin
        hdr_q <= {3'b000, bus.hdr_length, bus.hdr_version, 1'b1, bus.hdr_type};
      end
      if (swap) begin
        header_q <= hdr_q;
        sub_q    <= pack_pb(pb_next);
        valid_q  <= 1'b1;
      end
    end
  end

  assign bus.busy         = busy;
  assign bus.valid        = valid_q;
  assign bus.updated      = updated_q;
  assign bus.length_error = lerr_q;
  assign bus.header       = header_q;
  assign bus.sub          = sub_q;

endmodule

// File: doc/info_frame_builder.md
Name: info_frame_builder

Overview:
- Runtime-programmable HDMI InfoFrame packet source.
- Replaces fixed-parameter InfoFrame generation with a shadow payload RAM that firmware or control logic writes byte-by-byte.
- On commit, computes the InfoFrame checksum sequentially, then swaps the result into an active buffer. The swap happens only when the packet scheduler is not mid-transmission.
- Sits between the control/config path and the packet picker; drives the same 24-bit header and four 56-bit subpacket outputs.

Parameters:
- MAX_PAYLOAD, 27: payload bytes held (PB1..PB[MAX_PAYLOAD]). Legal range 1..27.
- CLEAR_ON_SWAP, 0: when 1, the shadow buffer is zeroed in the same cycle as the swap.

Ports:
- clk_pixel  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  shadow byte write strobe
- wr_addr  in  5  payload index 0..MAX_PAYLOAD-1, mapping to PB1..PB[MAX_PAYLOAD]
- wr_data  in  8  payload byte
- hdr_type  in  7  InfoFrame type (header byte 0 = {1'b1, hdr_type})
- hdr_version  in  8  header byte 1
- hdr_length  in  5  payload length, header byte 2 = {3'b0, hdr_length}
- commit  in  1  request checksum and swap
- hold  in  1  scheduler is transmitting the active packet; defer swap
- busy  out  1  commit in progress
- valid  out  1  active buffer holds a checksummed packet
- updated  out  1  one-cycle pulse on swap
- length_error  out  1  one-cycle pulse, commit rejected
- header  out  24  active header
- sub  out  [3:0][55:0]  active subpackets

Behaviour:
- Reset values:
  - busy, valid, updated, length_error = 0; header = 0; sub = 0.
  - Shadow buffer and latched header are zeroed.
  - FSM goes to IDLE. Any in-progress commit is abandoned.
- Writes:
  - Accepted only when busy=0 and wr_addr < MAX_PAYLOAD. Otherwise ignored silently.
  - A write in the same cycle as an accepted commit does land, and is included in that commit.
- Commit acceptance:
  - Evaluated only when busy=0. Commits while busy=1 are ignored.
  - If hdr_length > MAX_PAYLOAD: length_error=1 for one cycle, no state change.
  - Otherwise, at the accepting edge E0:
    - Latch the three header bytes.
    - acc = sum of the header bytes, mod 256.
    - idx = 0; busy = 1; state = SUM.
- SUM state:
  - Each edge: acc += (idx < latched length) ? shadow[idx] : 0; idx++.
  - After the add with idx = MAX_PAYLOAD-1 (edge E_MAX_PAYLOAD), go to SWAP.
- SWAP state:
  - On an edge with hold=0:
    - Active header = latched header.
    - PB0 = (~acc) + 1, 8-bit.
    - PB1..PB27 = shadow bytes with index < length; all others 0.
    - valid=1; updated=1 for one cycle; busy=0; state = IDLE.
  - On an edge with hold=1: stay in SWAP, outputs unchanged.
  - Nominal latency with hold low: busy high for MAX_PAYLOAD+1 cycles; new outputs visible after edge E(MAX_PAYLOAD+1).
- Output packing:
  - sub[i] = {PB[7i+6], …, PB[7i]}, PB0 in bits [7:0] of sub[0].
  - PB beyond MAX_PAYLOAD is 0.
- Output stability:
  - header and sub change only at the swap edge or on reset.
  - A commit accepted in the cycle right after a swap is legal.
- All sums are modulo 256. The shadow buffer persists across commits unless CLEAR_ON_SWAP=1.

Decomposition:
- Shared package hdmi_pkg:
  - info_frame_state_t enum (IDLE, SUM, SWAP).
  - Constant INFO_FRAME_MAX_PB = 27.
  - Function packing a 28-byte PB array into sub[3:0].
- One natural sub-module: info_frame_checksum_acc. Holds the accumulator and index counter and exposes a done flag.

Test Plan:
- AVI programming:
  - Stimulus: type 7'h02, version 8'h02, length 13, PB2=0x08, PB4=0x04, others 0; commit; hold=0.
  - Response: after MAX_PAYLOAD+1 cycles, header=24'h0D0282, sub[0]=56'h00000400080063, sub[1..3]=0, valid=1, one-cycle updated.
- Length masking:
  - Stimulus: as above, plus PB20=0xFF.
  - Response: outputs and checksum 0x63 are identical to the previous test; PB20 output = 0.
- Hold deferral:
  - Stimulus: hold=1 throughout the commit, then held 10 more cycles, then released.
  - Response: outputs unchanged and busy=1 while held; swap and updated on the first edge with hold=0.
- Rejection:
  - Stimulus: hdr_length=28 with MAX_PAYLOAD=27.
  - Response: length_error pulses once; busy stays 0; outputs unchanged.
  - Stimulus: commit or write while busy.
  - Response: ignored; the running checksum is unaffected.
- Reset mid-SUM:
  - Stimulus: assert reset at idx=10.
  - Response: next cycle all outputs are 0 and busy=0; a fresh commit completes normally.
- Back-to-back:
  - Stimulus: a commit asserted in the cycle right after updated, with a new PB4=0x10.
  - Response: accepted; second swap gives PB0=0x57 and PB4=0x10.
